multiply_accumulate_unit: RTL and testbench

MULTIPLY_ACCUMULATE_UNIT -- requirements
Module: multiply_accumulate_unit

---
 rtl/multiply_pkg.sv | 31 +++
 rtl/multiply_step.sv | 24 ++
 rtl/multiply_accumulate_unit.sv | 154 +++++++++++++++
 tb/tb_multiply_accumulate_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_pkg.sv
// Shared encodings for the multiply-accumulate unit: operation types, FSM states
// and small decode helpers used by the datapath.
package multiply_pkg;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MLA   = 3'b001;
    localparam logic [2:0] OP_UMULL = 3'b100;
    localparam logic [2:0] OP_UMLAL = 3'b101;
    localparam logic [2:0] OP_SMULL = 3'b110;
    localparam logic [2:0] OP_SMLAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mac_state_e;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

    function automatic logic op_is_long(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/multiply_step.sv
// One radix-2^STEP_BITS iteration: multiplies the magnitude by one multiplier digit,
// aligns the partial product to its digit position and adds it into the accumulator.
module multiply_step #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 8,
    parameter int CNT_W     = 2
) (
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [STEP_BITS-1:0] b_digit,
    input  logic [CNT_W-1:0]     step,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH+STEP_BITS-1:0] partial;
    logic [2*WIDTH-1:0]         shifted;

    always_comb begin
        partial = (WIDTH+STEP_BITS)'(a_mag) * (WIDTH+STEP_BITS)'(b_digit);
        shifted = (2*WIDTH)'(partial) << (int'(step) * STEP_BITS);
        acc_out = acc_in + shifted;
    end

endmodule

// File: rtl/multiply_accumulate_unit.sv
// Iterative multiply / multiply-accumulate unit (short, unsigned-long, signed-long).
// Define MAC_EARLY_TERM_EN to stop iterating once the remaining multiplier digits are zero.
module multiply_accumulate_unit
    import multiply_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 8
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op_type,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_n,
    output logic               flag_z,
    output logic               illegal
);

    localparam int N     = WIDTH / STEP_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    mac_state_e         state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   c_q;
    logic [WIDTH-1:0]   d_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   step_cnt;

    logic [2*WIDTH-1:0] step_sum;
    logic [WIDTH-1:0]   b_next;
    logic               calc_last;
    logic               signed_in;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] fixed;
    logic               fix_n;
    logic               fix_z;

    assign in_ready = (state == IDLE);

    multiply_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS),
        .CNT_W     (CNT_W)
    ) u_step (
        .acc_in  (acc),
        .a_mag   (a_mag),
        .b_digit (b_mag[STEP_BITS-1:0]),
        .step    (step_cnt),
        .acc_out (step_sum)
    );

    assign b_next = b_mag >> STEP_BITS;

`ifdef MAC_EARLY_TERM_EN
    assign calc_last = (step_cnt == LAST_STEP) || (b_next == '0);
`else
    assign calc_last = (step_cnt == LAST_STEP);
`endif

    // Signed operations iterate on magnitudes; the sign is restored in FIX.
    always_comb begin
        signed_in = op_is_signed(op_type);
        a_abs     = (signed_in && a[WIDTH-1]) ? -a : a;
        b_abs     = (signed_in && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        fixed = neg_q ? -acc : acc;
        case (op_q)
            OP_MLA:             fixed = fixed + (2*WIDTH)'(c_q);
            OP_UMLAL, OP_SMLAL: fixed = fixed + {c_q, d_q};
            default:            fixed = fixed;
        endcase
        if (!op_is_long(op_q)) begin
            fixed = {{WIDTH{1'b0}}, fixed[WIDTH-1:0]};
        end
        if (op_is_illegal(op_q)) begin
            fixed = '0;
        end
        fix_n = op_is_long(op_q) ? fixed[2*WIDTH-1] : fixed[WIDTH-1];
        fix_z = (fixed == '0);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            op_q      <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            c_q       <= '0;
            d_q       <= '0;
            neg_q     <= 1'b0;
            acc       <= '0;
            step_cnt  <= '0;
            result    <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_type;
                        a_mag    <= a_abs;
                        b_mag    <= b_abs;
                        c_q      <= c;
                        d_q      <= d;
                        neg_q    <= signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc      <= '0;
                        step_cnt <= '0;
                        state    <= op_is_illegal(op_type) ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc      <= step_sum;
                    b_mag    <= b_next;
                    step_cnt <= step_cnt + 1'b1;
                    if (calc_last) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result    <= fixed;
                    flag_n    <= fix_n;
                    flag_z    <= fix_z;
                    illegal   <= op_is_illegal(op_q);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_accumulate_unit.sv
// Directed testbench for multiply_accumulate_unit with an arithmetic reference model
// and a per-cycle compare process on the result interface.
module tb_multiply_accumulate_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op_type = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic [W-1:0] d = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic         flag_n;
    logic         flag_z;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_res = '0;
    logic           exp_n = 1'b0;
    logic           exp_z = 1'b0;
    logic           exp_ill = 1'b0;
    bit             exp_active = 1'b0;

    always #5 clk = ~clk;

    multiply_accumulate_unit #(.WIDTH(W), .STEP_BITS(8)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_type   (op_type),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .illegal   (illegal)
    );

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain full-width arithmetic on the architectural operands.
    function automatic void model(input logic [2:0] t, input logic [W-1:0] ma, mb, mc, md,
                                  output logic [2*W-1:0] r, output logic n, z, ill);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa  = $signed({{W{ma[W-1]}}, ma});
        sb  = $signed({{W{mb[W-1]}}, mb});
        r   = '0;
        ill = 1'b0;
        case (t)
            3'b000:  r = {{W{1'b0}}, ma * mb};
            3'b001:  r = {{W{1'b0}}, ma * mb + mc};
            3'b100:  r = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
            3'b101:  r = {{W{1'b0}}, ma} * {{W{1'b0}}, mb} + {mc, md};
            3'b110:  r = sa * sb;
            3'b111:  r = sa * sb + $signed({mc, md});
            default: ill = 1'b1;
        endcase
        if (t[2]) begin
            n = r[2*W-1];
            z = (r == '0);
        end else begin
            n = r[W-1];
            z = (r[W-1:0] == '0);
        end
    endfunction

    function automatic int expLatency(input logic [2:0] t, input logic [W-1:0] mb);
        logic [W-1:0] mag;
        int k;
        if (t[2:1] == 2'b01) return 1;
        mag = (t[2:1] == 2'b11 && mb[W-1]) ? -mb : mb;
        k = W / 8;
`ifdef MAC_EARLY_TERM_EN
        k = 1;
        while (k < W / 8 && (mag >> (8 * k)) != '0) k++;
`endif
        return k + 1;
    endfunction

    task automatic pinModel(input string name, input logic [2:0] t, input logic [W-1:0] ma, mb, mc, md,
                            input logic [2*W-1:0] lit_r, input logic lit_n, lit_z);
        logic [2*W-1:0] r;
        logic n, z, ill;
        model(t, ma, mb, mc, md, r, n, z, ill);
        checkOutput({name, "_model_result"}, r, lit_r);
        checkOutput({name, "_model_n"}, n, lit_n);
        checkOutput({name, "_model_z"}, z, lit_z);
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] t,
                                 input logic [W-1:0] va, vb, vc, vd, input int hold);
        int lat;
        bit seen;
        model(t, va, vb, vc, vd, exp_res, exp_n, exp_z, exp_ill);
        @(negedge clk);
        checkOutput({name, "_in_ready_idle"}, in_ready, 1);
        op_type  = t;
        a        = va;
        b        = vb;
        c        = vc;
        d        = vd;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_active = 1'b1;
        in_valid   = 1'b0;
        op_type    = 3'($urandom);
        a          = $urandom;
        b          = $urandom;
        c          = $urandom;
        d          = $urandom;
        checkOutput({name, "_busy"}, in_ready, 0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            seen = out_valid;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no out_valid, expected it within 40 cycles", name);
        end else begin
            checkOutput({name, "_latency"}, lat, expLatency(t, vb));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op_type  = 3'b100;
            a        = $urandom;
            b        = $urandom;
            checkOutput({name, "_hold_in_ready"}, in_ready, 0);
            checkOutput({name, "_hold_out_valid"}, out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        exp_active = 1'b0;
        checkOutput({name, "_released"}, out_valid, 0);
        checkOutput({name, "_no_same_cycle_accept"}, in_ready, 1);
        in_valid = 1'b0;
    endtask

    // Scoreboard compare on every cycle the result interface is valid.
    always @(negedge clk) begin
        if (n_reset && out_valid) begin
            if (!exp_active) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out_valid: got 1, expected 0");
            end else begin
                checkOutput("result", result, exp_res);
                checkOutput("flag_n", flag_n, exp_n);
                checkOutput("flag_z", flag_z, exp_z);
                checkOutput("illegal", illegal, exp_ill);
            end
        end
    end

    initial begin
        pinModel("mul_3x5", 3'b000, 32'd3, 32'd5, 32'd0, 32'd0, 64'h0000_0000_0000_000F, 1'b0, 1'b0);
        pinModel("mla_wrap", 3'b001, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
        pinModel("smull_neg", 3'b110, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0);
        pinModel("umull_max", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
        pinModel("smlal_zero", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 64'h0, 1'b0, 1'b1);

        #12;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_flags", {flag_n, flag_z, illegal}, 3'b000);
        @(negedge clk);
        n_reset = 1'b1;

        applyStimulus("mul_3x5", 3'b000, 32'd3, 32'd5, 32'd0, 32'd0, 0);
        applyStimulus("mla_wrap", 3'b001, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 0);
        applyStimulus("smull_neg", 3'b110, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 0);
        applyStimulus("umull_max", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 0);
        applyStimulus("smlal_zero", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 0);
        applyStimulus("illegal_010", 3'b010, 32'd7, 32'd9, 32'd1, 32'd1, 0);
        applyStimulus("illegal_011", 3'b011, 32'd7, 32'd9, 32'd1, 32'd1, 0);
        applyStimulus("umlal_mix", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1111_1111, 32'h2222_2222, 0);
        applyStimulus("smull_minmin", 3'b110, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0);
        applyStimulus("smlal_negpos", 3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd5, 0);
        applyStimulus("mul_by_zero", 3'b000, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 0);
        applyStimulus("mla_mid_b", 3'b001, 32'h0000_0123, 32'h0001_0200, 32'h0000_0042, 32'd0, 0);
        applyStimulus("mla_hold", 3'b001, 32'h0001_0000, 32'h0000_8000, 32'h0000_0012, 32'd0, 10);

        // Reset in the second CALC cycle must drop the operation entirely.
        @(negedge clk);
        op_type  = 3'b000;
        a        = 32'd7;
        b        = 32'h0102_0304;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b0;
        #1;
        checkOutput("midcalc_reset_result", result, 0);
        checkOutput("midcalc_reset_flags", {flag_n, flag_z, illegal}, 3'b000);
        checkOutput("midcalc_reset_out_valid", out_valid, 0);
        checkOutput("midcalc_reset_in_ready", in_ready, 1);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("after_reset_no_result", out_valid, 0);
        checkOutput("after_reset_idle", in_ready, 1);

        applyStimulus("mul_after_reset", 3'b000, 32'd3, 32'd5, 32'd0, 32'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
